switch_debounce_edge: RTL and testbench

Debounces and edge-detects a raw mechanical push-button input and produces the clean, single-cycle press/release events that downstream toggle and LED logic consume. Sits between the switch input pad and any user-interface logic. Downstream blocks then no longer need their own edge registers or glitch filtering. Includes a two-flop synchronizer, a stability counter and a four-state debounce FSM, with an optional long-press detector.

---
 rtl/switch_debounce_edge.sv | 128 ++++++++++++
 tb/tb_switch_debounce_edge.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce_edge.sv
// rtl/switch_debounce_edge.sv - push-button synchronizer, debouncer and press/release edge detector
// Optional long-press detector enabled by defining SWITCH_DEBOUNCE_LONG_PRESS_EN.
module switch_debounce_edge #(
  parameter int DEBOUNCE_LIMIT   = 250000,
  parameter int LONG_PRESS_LIMIT = 25000000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Long_Press
);

  localparam int CNT_W = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    CHK_HIGH = 2'd1,
    HIGH     = 2'd2,
    CHK_LOW  = 2'd3
  } state_t;

  state_t           state;
  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] count;
  logic             accept_press;

  assign accept_press = (state == CHK_HIGH) && sync2 && (count == CNT_LAST);

`ifdef SWITCH_DEBOUNCE_LONG_PRESS_EN
  localparam int LONG_W = $clog2(LONG_PRESS_LIMIT + 1);
  localparam logic [LONG_W-1:0] LONG_ONE = LONG_W'(1);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_PRESS_LIMIT);

  logic [LONG_W-1:0] long_count;

  // Counting starts at 1 on the press cycle and saturates at the limit, so one pulse per press.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      long_count   <= '0;
      o_Long_Press <= 1'b0;
    end else begin
      o_Long_Press <= 1'b0;
      if (accept_press) begin
        long_count   <= LONG_ONE;
        o_Long_Press <= (LONG_ONE == LONG_MAX);
      end else if (!o_Switch) begin
        long_count <= '0;
      end else if (long_count != LONG_MAX) begin
        long_count <= long_count + LONG_ONE;
        if (long_count + LONG_ONE == LONG_MAX) begin
          o_Long_Press <= 1'b1;
        end
      end
    end
  end
`else
  // Port kept so both builds instantiate identically; the comparison is constant false.
  assign o_Long_Press = (LONG_PRESS_LIMIT < 0);
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      count     <= '0;
      state     <= LOW;
      o_Switch  <= 1'b0;
      o_Press   <= 1'b0;
      o_Release <= 1'b0;
    end else begin
      sync1     <= i_Switch;
      sync2     <= sync1;
      o_Press   <= 1'b0;
      o_Release <= 1'b0;
      case (state)
        LOW: begin
          if (sync2) begin
            state <= CHK_HIGH;
            count <= CNT_ONE;
          end
        end
        CHK_HIGH: begin
          if (!sync2) begin
            state <= LOW;
            count <= '0;
          end else if (count == CNT_LAST) begin
            state    <= HIGH;
            count    <= '0;
            o_Switch <= 1'b1;
            o_Press  <= 1'b1;
          end else begin
            count <= count + CNT_ONE;
          end
        end
        HIGH: begin
          if (!sync2) begin
            state <= CHK_LOW;
            count <= CNT_ONE;
          end
        end
        CHK_LOW: begin
          if (sync2) begin
            state <= HIGH;
            count <= '0;
          end else if (count == CNT_LAST) begin
            state     <= LOW;
            count     <= '0;
            o_Switch  <= 1'b0;
            o_Release <= 1'b1;
          end else begin
            count <= count + CNT_ONE;
          end
        end
        default: begin
          state <= LOW;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_debounce_edge.sv
// tb/tb_switch_debounce_edge.sv - directed bench for switch_debounce_edge
// DEBOUNCE_LIMIT=4, LONG_PRESS_LIMIT=10; long-press checks follow SWITCH_DEBOUNCE_LONG_PRESS_EN.
module tb_switch_debounce_edge;

  logic i_Clk;
  logic i_Rst_L;
  logic i_Switch;
  logic o_Switch;
  logic o_Press;
  logic o_Release;
  logic o_Long_Press;

  int checks;
  int errors;

  switch_debounce_edge #(
    .DEBOUNCE_LIMIT  (4),
    .LONG_PRESS_LIMIT(10)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Rst_L     (i_Rst_L),
    .i_Switch    (i_Switch),
    .o_Switch    (o_Switch),
    .o_Press     (o_Press),
    .o_Release   (o_Release),
    .o_Long_Press(o_Long_Press)
  );

  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    i_Rst_L  = 1'b0;
    i_Switch = 1'b0;
    idle(3);
    checks++;
    if (o_Switch !== 1'b0) begin errors++; $display("FAIL reset_switch got %b want 0", o_Switch); end
    checks++;
    if (o_Press !== 1'b0) begin errors++; $display("FAIL reset_press got %b want 0", o_Press); end
    checks++;
    if (o_Release !== 1'b0) begin errors++; $display("FAIL reset_release got %b want 0", o_Release); end
    checks++;
    if (o_Long_Press !== 1'b0) begin errors++; $display("FAIL reset_long got %b want 0", o_Long_Press); end
    i_Rst_L = 1'b1;
    idle(3);
  endtask

  // Tick k lands just after edge N0+k-1; press expected after edge N0+5 (k==6).
  task automatic test_clean_press();
    i_Switch = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (o_Switch !== (k >= 6)) begin errors++; $display("FAIL press_switch k=%0d got %b want %b", k, o_Switch, (k >= 6)); end
      checks++;
      if (o_Press !== (k == 6)) begin errors++; $display("FAIL press_pulse k=%0d got %b want %b", k, o_Press, (k == 6)); end
      checks++;
      if (o_Release !== 1'b0) begin errors++; $display("FAIL press_release k=%0d got %b want 0", k, o_Release); end
    end
  endtask

  task automatic test_release();
    i_Switch = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (o_Switch !== (k < 6)) begin errors++; $display("FAIL release_switch k=%0d got %b want %b", k, o_Switch, (k < 6)); end
      checks++;
      if (o_Release !== (k == 6)) begin errors++; $display("FAIL release_pulse k=%0d got %b want %b", k, o_Release, (k == 6)); end
      checks++;
      if (o_Press !== 1'b0) begin errors++; $display("FAIL release_press k=%0d got %b want 0", k, o_Press); end
    end
  endtask

  // Pattern sample i is taken at edge Ei; last 0->1 sample is E4, so press lands on E9.
  task automatic test_bounce();
    logic [11:0] pat;
    pat = 12'b1111_1111_0111;
    for (int i = 0; i < 12; i++) begin
      i_Switch = pat[i];
      tick();
      checks++;
      if (o_Press !== (i == 9)) begin errors++; $display("FAIL bounce_press i=%0d got %b want %b", i, o_Press, (i == 9)); end
      checks++;
      if (o_Switch !== (i >= 9)) begin errors++; $display("FAIL bounce_switch i=%0d got %b want %b", i, o_Switch, (i >= 9)); end
    end
    i_Switch = 1'b0;
    idle(10);
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 14; i++) begin
      i_Switch = (i < 3);
      tick();
      checks++;
      if ({o_Switch, o_Press, o_Release} !== 3'b000) begin
        errors++;
        $display("FAIL glitch i=%0d got sw/pr/rl=%b%b%b want 000", i, o_Switch, o_Press, o_Release);
      end
    end
  endtask

  task automatic test_reset_mid();
    // Reset while debounced high must clear o_Switch before any clock edge.
    i_Switch = 1'b1;
    idle(10);
    checks++;
    if (o_Switch !== 1'b1) begin errors++; $display("FAIL pre_reset_high got %b want 1", o_Switch); end
    #2 i_Rst_L = 1'b0;
    #1;
    checks++;
    if (o_Switch !== 1'b0) begin errors++; $display("FAIL async_reset_switch got %b want 0", o_Switch); end
    tick();
    i_Rst_L = 1'b1;
    i_Switch = 1'b0;
    idle(4);
    // Press, then reset two cycles into CHK_HIGH (edges E0..E3 elapsed).
    i_Switch = 1'b1;
    idle(4);
    #2 i_Rst_L = 1'b0;
    #1;
    checks++;
    if ({o_Switch, o_Press, o_Release, o_Long_Press} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset got %b%b%b%b want 0000", o_Switch, o_Press, o_Release, o_Long_Press);
    end
    tick();
    tick();
    i_Rst_L = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (o_Press !== (k == 6)) begin errors++; $display("FAIL post_reset_press k=%0d got %b want %b", k, o_Press, (k == 6)); end
      checks++;
      if (o_Switch !== (k >= 6)) begin errors++; $display("FAIL post_reset_switch k=%0d got %b want %b", k, o_Switch, (k >= 6)); end
    end
    i_Switch = 1'b0;
    idle(10);
  endtask

  task automatic test_long_press();
    logic want;
    i_Switch = 1'b1;
    idle(6);
    checks++;
    if (o_Press !== 1'b1) begin errors++; $display("FAIL long_setup_press got %b want 1", o_Press); end
    for (int k = 1; k <= 30; k++) begin
      tick();
`ifdef SWITCH_DEBOUNCE_LONG_PRESS_EN
      want = (k == 9);
`else
      want = 1'b0;
`endif
      checks++;
      if (o_Long_Press !== want) begin errors++; $display("FAIL long_hold k=%0d got %b want %b", k, o_Long_Press, want); end
    end
    i_Switch = 1'b0;
    idle(10);
    // Short press: o_Switch stays high only 6 cycles, well under the limit.
    i_Switch = 1'b1;
    idle(6);
    i_Switch = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      checks++;
      if (o_Long_Press !== 1'b0) begin errors++; $display("FAIL long_short k=%0d got %b want 0", k, o_Long_Press); end
    end
    checks++;
    if (o_Switch !== 1'b0) begin errors++; $display("FAIL long_short_end got %b want 0", o_Switch); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    i_Rst_L  = 1'b0;
    i_Switch = 1'b0;
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_glitch();
    test_reset_mid();
    test_long_press();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
